mot_pwm_gen: RTL and testbench



---
 rtl/mot_pwm_gen.sv | 134 +++++++++++++
 tb/tb_mot_pwm_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mot_pwm_gen.sv
// Four-channel DC motor PWM / H-bridge drive stage: shared prescaled period counter,
// per-motor duty shadows loaded at period wrap, dead-time coast FSM and brake override.
module mot_pwm_gen #(
  parameter int PRESCALE = 4,
  parameter int DEADTIME = 16
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic [11:0] mot_duty0,
  input  logic [11:0] mot_duty1,
  input  logic [11:0] mot_duty2,
  input  logic [11:0] mot_duty3,
  input  logic [7:0]  mot_drive_code,
  input  logic [4:0]  mot_allstop,
  output logic [3:0]  mot_out_a,
  output logic [3:0]  mot_out_b,
  output logic        pwm_sync
);

  localparam logic [11:0] PCNT_LAST = 12'd4094;
  localparam logic [7:0]  PRE_LAST  = 8'(PRESCALE - 1);
  localparam logic [7:0]  DT_LOAD   = 8'(DEADTIME - 1);

  typedef enum logic {ST_RUN, ST_DEAD} state_t;

  logic [7:0]  pre_cnt_q;
  logic [11:0] pcnt_q;
  logic        sync_q;
  logic [4:0]  stop_q;
  logic        tick;
  logic        wrap;
  logic [11:0] duty_in [4];

  assign duty_in[0] = mot_duty0;
  assign duty_in[1] = mot_duty1;
  assign duty_in[2] = mot_duty2;
  assign duty_in[3] = mot_duty3;

  assign tick     = (pre_cnt_q == PRE_LAST);
  assign wrap     = tick && (pcnt_q == PCNT_LAST);
  assign pwm_sync = sync_q;

  // Period is 4095 ticks so that a duty of 4095 never drops low.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      pre_cnt_q <= 8'd0;
      pcnt_q    <= 12'd0;
      sync_q    <= 1'b0;
      stop_q    <= 5'd0;
    end else begin
      pre_cnt_q <= tick ? 8'd0 : pre_cnt_q + 8'd1;
      if (tick) begin
        pcnt_q <= wrap ? 12'd0 : pcnt_q + 12'd1;
      end
      sync_q <= wrap;
      stop_q <= mot_allstop;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_motor
    logic [11:0] shadow_q;
    state_t      state_q;
    logic [1:0]  act_q;
    logic [7:0]  dt_q;
    logic        a_q;
    logic        b_q;
    logic        a_d;
    logic        b_d;
    logic        pwm;
    logic [1:0]  code_in;

    assign code_in = mot_drive_code[2*gi +: 2];
    assign pwm     = (pcnt_q < shadow_q);

    always_comb begin
      a_d = 1'b0;
      b_d = 1'b0;
      case (act_q)
        2'b01:   a_d = pwm;
        2'b10:   b_d = pwm;
        2'b11: begin
          a_d = 1'b1;
          b_d = 1'b1;
        end
        default: ;
      endcase
      if (stop_q[4] || stop_q[gi]) begin
        a_d = 1'b1;
        b_d = 1'b1;
      end
    end

    // The input slice is only sampled again at dead-time expiry; any later
    // difference is caught by the next RUN cycle and starts a fresh coast.
    always_ff @(posedge SYS_CLK) begin
      if (SYS_RST) begin
        shadow_q <= 12'd0;
        state_q  <= ST_RUN;
        act_q    <= 2'b00;
        dt_q     <= 8'd0;
        a_q      <= 1'b0;
        b_q      <= 1'b0;
      end else begin
        if (wrap) begin
          shadow_q <= duty_in[gi];
        end
        case (state_q)
          ST_RUN: begin
            if (code_in != act_q) begin
              act_q   <= 2'b00;
              dt_q    <= DT_LOAD;
              state_q <= ST_DEAD;
            end
          end
          ST_DEAD: begin
            if (dt_q == 8'd0) begin
              act_q   <= code_in;
              state_q <= ST_RUN;
            end else begin
              dt_q <= dt_q - 8'd1;
            end
          end
          default: state_q <= ST_RUN;
        endcase
        a_q <= a_d;
        b_q <= b_d;
      end
    end

    assign mot_out_a[gi] = a_q;
    assign mot_out_b[gi] = b_q;
  end

endmodule

// File: tb/tb_mot_pwm_gen.sv
// Directed bench for mot_pwm_gen: one instance at PRESCALE=1, one at PRESCALE=4,
// both fed from the same stimulus; expected counts and patterns are hand-derived.
module tb_mot_pwm_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] d0, d1, d2, d3;
  logic [7:0]  code;
  logic [4:0]  stop;
  logic [3:0]  a0, b0, a1, b1;
  logic        s0, s1;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mot_pwm_gen #(.PRESCALE(1), .DEADTIME(16)) u_dut (
    .SYS_CLK(clk), .SYS_RST(rst),
    .mot_duty0(d0), .mot_duty1(d1), .mot_duty2(d2), .mot_duty3(d3),
    .mot_drive_code(code), .mot_allstop(stop),
    .mot_out_a(a0), .mot_out_b(b0), .pwm_sync(s0)
  );

  mot_pwm_gen #(.PRESCALE(4), .DEADTIME(16)) u_dut_p4 (
    .SYS_CLK(clk), .SYS_RST(rst),
    .mot_duty0(d0), .mot_duty1(d1), .mot_duty2(d2), .mot_duty3(d3),
    .mot_drive_code(code), .mot_allstop(stop),
    .mot_out_a(a1), .mot_out_b(b1), .pwm_sync(s1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_sync(input int sel, input int bound);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (((sel == 0) ? !s0 : !s1) && n < bound);
    check((sel == 0) ? "sync0_seen" : "sync1_seen", (sel == 0) ? s0 : s1, 1);
  endtask

  initial begin
    int ca0, ca1, ca2, ca3, cb, cs, nz;

    rst = 1'b1; d0 = 12'd77; d1 = 12'd88; d2 = 12'd99; d3 = 12'd111;
    code = 8'hAA; stop = 5'h1F;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_a", a0, 0);
      check("rst_b", b0, 0);
      check("rst_sync", s0, 0);
    end

    rst = 1'b0; d0 = 12'd1024; d1 = 12'd1; d2 = 12'd0; d3 = 12'd4095;
    code = 8'h55; stop = 5'h00;
    wait_sync(0, 4200);

    // First period: duty 1024 stays in force despite a mid-period write of 3000.
    ca0 = 0; ca1 = 0; ca2 = 0; ca3 = 0; cb = 0; cs = 0;
    for (int i = 1; i <= 4095; i++) begin
      step();
      ca0 += int'(a0[0]); ca1 += int'(a0[1]); ca2 += int'(a0[2]); ca3 += int'(a0[3]);
      cb += int'(b0 != 4'h0); cs += int'(s0);
      if (i == 100) d0 = 12'd3000;
    end
    check("fwd_duty1024", ca0, 1024);
    check("duty1_one_tick", ca1, 1);
    check("duty0_const_low", ca2, 0);
    check("duty4095_const_high", ca3, 4095);
    check("fwd_b_low", cb, 0);
    check("sync_once_per_period", cs, 1);
    check("sync_period_4095", s0, 1);

    ca0 = 0;
    for (int i = 1; i <= 4095; i++) begin
      step();
      ca0 += int'(a0[0]);
    end
    check("next_period_duty3000", ca0, 3000);
    check("sync_period_4095_b", s0, 1);

    wait_sync(1, 20000);
    ca1 = 0; ca3 = 0; cs = 0;
    for (int i = 1; i <= 16380; i++) begin
      step();
      ca1 += int'(a1[1]); ca3 += int'(a1[3]); cs += int'(s1);
    end
    check("p4_duty1_four_cycles", ca1, 4);
    check("p4_duty4095_high", ca3, 16380);
    check("p4_sync_once", cs, 1);

    d0 = 12'd2000;
    wait_sync(0, 4200);
    code = 8'h56;
    step();
    check("rev_before_a", a0[0], 1);
    check("rev_before_b", b0[0], 0);
    nz = 0;
    for (int i = 2; i <= 17; i++) begin
      step();
      nz += int'(a0[0] | b0[0]);
    end
    check("rev_coast16", nz, 0);
    step();
    check("rev_after_a", a0[0], 0);
    check("rev_after_b", b0[0], 1);

    wait_sync(0, 4200);
    code = 8'h55;
    for (int i = 1; i <= 5; i++) step();
    code = 8'h56;
    for (int i = 6; i <= 10; i++) step();
    check("toggle_in_dead", {a0[0], b0[0]}, 0);
    for (int i = 11; i <= 18; i++) step();
    check("toggle_final_a", a0[0], 0);
    check("toggle_final_b", b0[0], 1);
    step();
    check("toggle_no_redead", b0[0], 1);

    wait_sync(0, 4200);
    code = 8'h55;
    for (int i = 1; i <= 17; i++) step();
    code = 8'h56;
    step();
    check("redead_brief_fwd", {a0[0], b0[0]}, 2'b10);
    nz = 0;
    for (int i = 19; i <= 34; i++) begin
      step();
      nz += int'(a0[0] | b0[0]);
    end
    check("redead_coast16", nz, 0);
    step();
    check("redead_rev", {a0[0], b0[0]}, 2'b01);

    wait_sync(0, 4200);
    code = 8'h55; stop = 5'h10;
    step();
    check("stop_lat1_a", a0, 4'b1010);
    check("stop_lat1_b", b0, 4'b0001);
    step();
    check("stop_dead_a", a0, 4'hF);
    check("stop_dead_b", b0, 4'hF);
    for (int i = 3; i <= 10; i++) step();
    stop = 5'h00;
    step();
    check("stop_rel_lat1", a0, 4'hF);
    step();
    check("stop_rel_a", a0, 4'b1000);
    check("stop_rel_b", b0, 4'b0000);
    for (int i = 13; i <= 20; i++) step();
    check("run_fwd_a", a0, 4'b1001);
    stop = 5'h10;
    step();
    check("stop_run_lat1", a0, 4'b1001);
    step();
    check("stop_run_a", a0, 4'hF);
    check("stop_run_b", b0, 4'hF);
    stop = 5'h00;
    step();
    step();
    check("stop_run_rel", a0, 4'b1001);
    stop = 5'h02;
    step();
    step();
    check("stop_m1_a", a0, 4'b1011);
    check("stop_m1_b", b0, 4'b0010);
    stop = 5'h00;
    step();

    rst = 1'b1;
    step();
    check("midrst_a", a0, 0);
    check("midrst_b", b0, 0);
    check("midrst_sync", s0, 0);
    rst = 1'b0; code = 8'hFF;
    for (int i = 1; i <= 17; i++) step();
    check("post_rst_coast", {a0, b0}, 0);
    step();
    check("post_rst_brake_a", a0, 4'hF);
    check("post_rst_brake_b", b0, 4'hF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
